// File: rtl/usr_pkg.sv
// Shared types and constants for the universal shift register and its burst controller.
package usr_pkg;

   typedef enum logic [2:0] {
      OP_HOLD = 3'b000,
      OP_SHL  = 3'b001,
      OP_SHR  = 3'b010,
      OP_LOAD = 3'b011,
      OP_ROL  = 3'b100,
      OP_ROR  = 3'b101,
      OP_ASR  = 3'b110,
      OP_CLR  = 3'b111
   } usr_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } usr_state_e;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst sequencer: counts programmed shifts, drives shift enable/direction to the datapath
// and pulses done when the final shift lands (or at once for a zero-length burst).
module usr_burst_ctrl
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             burst_start_i,
   input  logic [CNT_W-1:0] burst_len_i,
   input  logic             burst_dir_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             shift_en_o,
   output logic             shift_dir_o,
   output logic             start_o,
   output logic             op_block_o
);

   localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(WIDTH);

   usr_state_e       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] len_sat;

   assign len_sat = (burst_len_i > MAX_LEN) ? MAX_LEN : burst_len_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         dir_q   <= DIR_RIGHT;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      dir_d   = dir_q;
      done_d  = 1'b0;
      start_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (burst_start_i) begin
               if (len_sat != '0) begin
                  count_d = len_sat;
                  dir_d   = burst_dir_i;
                  state_d = RUN;
                  start_o = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            count_d = count_q - 1'b1;
            // The shift executed this cycle is the last one; done lines up with the final po.
            if (count_q == CNT_W'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o      = (state_q == RUN);
   assign done_o      = done_q;
   assign shift_en_o  = (state_q == RUN);
   assign shift_dir_o = dir_q;
   assign op_block_o  = (state_q == RUN) || burst_start_i;

endmodule

// File: rtl/usr_shift_reg_param.sv
// Universal shift register with eight single-cycle ops and an autonomous burst shift mode.
// Defining USR_PARITY_EN adds a registered even-parity output that always equals ^po.
module usr_shift_reg_param
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       op,
   input  logic             si,
   input  logic [WIDTH-1:0] pi,
   input  logic             burst_start,
   input  logic [CNT_W-1:0] burst_len,
   input  logic             burst_dir,
   output logic [WIDTH-1:0] po,
   output logic             so,
   output logic             busy,
   output logic             done
`ifdef USR_PARITY_EN
   ,
   output logic             parity
`endif
);

   logic [WIDTH-1:0] po_q, po_d;
   logic             last_dir_q, last_dir_d;
   logic             shift_en, shift_dir, burst_go, op_block;

   usr_burst_ctrl #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) u_ctrl (
      .clk          (clk),
      .rst          (rst),
      .burst_start_i(burst_start),
      .burst_len_i  (burst_len),
      .burst_dir_i  (burst_dir),
      .busy_o       (busy),
      .done_o       (done),
      .shift_en_o   (shift_en),
      .shift_dir_o  (shift_dir),
      .start_o      (burst_go),
      .op_block_o   (op_block)
   );

   always_comb begin
      po_d       = po_q;
      last_dir_d = last_dir_q;
      if (shift_en) begin
         if (shift_dir == DIR_RIGHT) po_d = {si, po_q[WIDTH-1:1]};
         else                        po_d = {po_q[WIDTH-2:0], si};
      end else if (burst_go) begin
         last_dir_d = burst_dir;
      end else if (!op_block && en) begin
         case (usr_op_e'(op))
            OP_SHL: begin
               po_d       = {po_q[WIDTH-2:0], si};
               last_dir_d = DIR_LEFT;
            end
            OP_SHR: begin
               po_d       = {si, po_q[WIDTH-1:1]};
               last_dir_d = DIR_RIGHT;
            end
            OP_LOAD: po_d = pi;
            OP_ROL: begin
               po_d       = {po_q[WIDTH-2:0], po_q[WIDTH-1]};
               last_dir_d = DIR_LEFT;
            end
            OP_ROR: begin
               po_d       = {po_q[0], po_q[WIDTH-1:1]};
               last_dir_d = DIR_RIGHT;
            end
            OP_ASR: begin
               po_d       = {po_q[WIDTH-1], po_q[WIDTH-1:1]};
               last_dir_d = DIR_RIGHT;
            end
            OP_CLR:  po_d = '0;
            default: po_d = po_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         po_q       <= '0;
         last_dir_q <= DIR_RIGHT;
      end else begin
         po_q       <= po_d;
         last_dir_q <= last_dir_d;
      end
   end

   assign po = po_q;
   // so is the bit the next shift in the most recent direction would push out.
   assign so = (last_dir_q == DIR_RIGHT) ? po_q[0] : po_q[WIDTH-1];

`ifdef USR_PARITY_EN
   logic parity_q;

   always_ff @(posedge clk) begin
      if (rst) parity_q <= 1'b0;
      else     parity_q <= ^po_d;
   end

   assign parity = parity_q;
`endif

endmodule

// File: tb/tb_usr_shift_reg_param.sv
// Randomized self-checking bench for usr_shift_reg_param (WIDTH=8) against an arithmetic reference model.
module tb_usr_shift_reg_param;

   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [2:0] op;
   logic       si;
   logic [7:0] pi;
   logic       burst_start;
   logic [3:0] burst_len;
   logic       burst_dir;
   logic [7:0] po;
   logic       so;
   logic       busy;
   logic       done;
`ifdef USR_PARITY_EN
   logic       parity;
`endif

   int   total = 0;
   int   bad   = 0;
   int   m_po  = 0;
   logic m_dir = 1'b1;

   usr_shift_reg_param #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .op         (op),
      .si         (si),
      .pi         (pi),
      .burst_start(burst_start),
      .burst_len  (burst_len),
      .burst_dir  (burst_dir),
      .po         (po),
      .so         (so),
      .busy       (busy),
      .done       (done)
`ifdef USR_PARITY_EN
      ,
      .parity     (parity)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got busy=%b required finish", busy);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: register value as an integer 0..255, ops as plain arithmetic.
   task automatic model_op(input int o, input int s, input int p);
      case (o)
         1: begin m_po = (m_po * 2) % 256 + s;                    m_dir = 1'b0; end
         2: begin m_po = m_po / 2 + s * 128;                      m_dir = 1'b1; end
         3: m_po = p;
         4: begin m_po = (m_po * 2) % 256 + m_po / 128;           m_dir = 1'b0; end
         5: begin m_po = m_po / 2 + (m_po % 2) * 128;             m_dir = 1'b1; end
         6: begin m_po = m_po / 2 + ((m_po >= 128) ? 128 : 0);    m_dir = 1'b1; end
         7: m_po = 0;
         default: ;
      endcase
   endtask

   task automatic model_shift(input logic right, input int s);
      if (right) m_po = m_po / 2 + s * 128;
      else       m_po = (m_po * 2) % 256 + s;
   endtask

   function automatic logic exp_so();
      return m_dir ? 1'(m_po) : 1'(m_po >> 7);
   endfunction

   function automatic logic exp_par();
      return 1'($countones(m_po));
   endfunction

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; op = 3'b011; pi = 8'hFF; si = 1'b1;
      burst_start = 1'b1; burst_len = 4'd3; burst_dir = 1'b0;
      tick(); tick();
      m_po = 0; m_dir = 1'b1;
      total += 4;
      if (po !== 8'h00)  begin bad++; $display("FAIL reset_po: got %h want 00", po); end
      if (so !== 1'b0)   begin bad++; $display("FAIL reset_so: got %b want 0", so); end
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
`ifdef USR_PARITY_EN
      total++;
      if (parity !== 1'b0) begin bad++; $display("FAIL reset_parity: got %b want 0", parity); end
`endif
      rst = 1'b0; burst_start = 1'b0; en = 1'b0;
      tick();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy: got %b want 0", busy); end
      $display("txn reset: po=%h so=%b busy=%b done=%b", po, so, busy, done);
   endtask

   logic [2:0] d_op [12] = '{3'd3, 3'd1, 3'd3, 3'd4, 3'd3, 3'd6, 3'd3, 3'd5, 3'd2, 3'd7, 3'd3, 3'd1};
   logic       d_en [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic       d_si [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   logic [7:0] d_pi [12] = '{8'hA5, 8'h00, 8'hA5, 8'h00, 8'hA5, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00, 8'h3C, 8'hFF};
   logic [7:0] d_ex [12] = '{8'hA5, 8'h4A, 8'hA5, 8'h4B, 8'hA5, 8'hD2, 8'h81, 8'hC0, 8'hE0, 8'h00, 8'h3C, 8'h3C};

   task automatic test_directed_ops();
      for (int i = 0; i < 12; i++) begin
         en = d_en[i]; op = d_op[i]; si = d_si[i]; pi = d_pi[i]; burst_start = 1'b0;
         tick();
         if (d_en[i]) model_op(int'(d_op[i]), int'(d_si[i]), int'(d_pi[i]));
         total += 2;
         if (po !== d_ex[i]) begin bad++; $display("FAIL directed_po[%0d]: got %h want %h", i, po, d_ex[i]); end
         if (so !== exp_so()) begin bad++; $display("FAIL directed_so[%0d]: got %b want %b", i, so, exp_so()); end
         $display("txn directed %0d: en=%b op=%0d si=%b pi=%h -> po=%h so=%b", i, d_en[i], d_op[i], d_si[i], d_pi[i], po, so);
      end
   endtask

   task automatic test_random_ops();
      int o, s, p;
      logic e;
      for (int i = 0; i < 150; i++) begin
         o = $urandom_range(0, 7); s = $urandom_range(0, 1); p = $urandom_range(0, 255);
         e = ($urandom_range(0, 3) != 0);
         en = e; op = 3'(o); si = 1'(s); pi = 8'(p); burst_start = 1'b0;
         burst_len = 4'($urandom); burst_dir = 1'($urandom);
         tick();
         if (e) model_op(o, s, p);
         total += 4;
         if (po !== 8'(m_po)) begin bad++; $display("FAIL random_po[%0d]: got %h want %h", i, po, 8'(m_po)); end
         if (so !== exp_so()) begin bad++; $display("FAIL random_so[%0d]: got %b want %b", i, so, exp_so()); end
         if (busy !== 1'b0)   begin bad++; $display("FAIL random_busy[%0d]: got %b want 0", i, busy); end
         if (done !== 1'b0)   begin bad++; $display("FAIL random_done[%0d]: got %b want 0", i, done); end
`ifdef USR_PARITY_EN
         total++;
         if (parity !== exp_par()) begin bad++; $display("FAIL random_parity[%0d]: got %b want %b", i, parity, exp_par()); end
`endif
         $display("txn random %0d: en=%b op=%0d si=%0d pi=%h -> po=%h so=%b", i, e, o, s, p, po, so);
      end
   endtask

   // Issues burst_start for one cycle and follows the burst to its done cycle; leaves the bench
   // in the done cycle so a caller can chain another start immediately.
   task automatic run_burst(input int len, input logic dir, input bit rand_si);
      int eff, cnt, s;
      eff = (len > W) ? W : len;
      burst_start = 1'b1; burst_len = 4'(len); burst_dir = dir;
      en = 1'b1; op = 3'b011; pi = 8'($urandom); si = 1'b1;
      tick();
      burst_start = 1'b0;
      if (eff == 0) begin
         total += 3;
         if (done !== 1'b1)   begin bad++; $display("FAIL burst0_done: got %b want 1", done); end
         if (busy !== 1'b0)   begin bad++; $display("FAIL burst0_busy: got %b want 0", busy); end
         if (po !== 8'(m_po)) begin bad++; $display("FAIL burst0_po: got %h want %h", po, 8'(m_po)); end
         $display("txn burst len=%0d dir=%b: zero-length, done=%b po=%h", len, dir, done, po);
         return;
      end
      m_dir = dir;
      total += 4;
      if (busy !== 1'b1)   begin bad++; $display("FAIL burst_start_busy: got %b want 1", busy); end
      if (done !== 1'b0)   begin bad++; $display("FAIL burst_start_done: got %b want 0", done); end
      if (po !== 8'(m_po)) begin bad++; $display("FAIL burst_start_po: got %h want %h", po, 8'(m_po)); end
      if (so !== exp_so()) begin bad++; $display("FAIL burst_start_so: got %b want %b", so, exp_so()); end
      cnt = 0;
      while (busy === 1'b1 && cnt <= W + 1) begin
         s = rand_si ? $urandom_range(0, 1) : 1;
         si = 1'(s); en = 1'($urandom); op = 3'($urandom); pi = 8'($urandom);
         burst_start = 1'($urandom); burst_dir = 1'($urandom); burst_len = 4'($urandom);
         tick();
         model_shift(dir, s);
         cnt++;
      end
      burst_start = 1'b0; en = 1'b0;
      total += 4;
      if (cnt != eff)      begin bad++; $display("FAIL burst_busy_cycles: got %0d want %0d", cnt, eff); end
      if (done !== 1'b1)   begin bad++; $display("FAIL burst_done: got %b want 1", done); end
      if (po !== 8'(m_po)) begin bad++; $display("FAIL burst_po: got %h want %h", po, 8'(m_po)); end
      if (so !== exp_so()) begin bad++; $display("FAIL burst_so: got %b want %b", so, exp_so()); end
`ifdef USR_PARITY_EN
      total++;
      if (parity !== exp_par()) begin bad++; $display("FAIL burst_parity: got %b want %b", parity, exp_par()); end
`endif
      $display("txn burst len=%0d dir=%b: busy_cycles=%0d done=%b po=%h", len, dir, cnt, done, po);
   endtask

   task automatic idle_after_done(input string tag);
      burst_start = 1'b0; en = 1'b0;
      tick();
      total += 2;
      if (done !== 1'b0) begin bad++; $display("FAIL %s_done_clear: got %b want 0", tag, done); end
      if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_idle: got %b want 0", tag, busy); end
   endtask

   task automatic test_burst();
      en = 1'b1; op = 3'b011; pi = 8'hF0; burst_start = 1'b0;
      tick();
      model_op(3, 0, 'hF0);
      run_burst(4, 1'b0, 1'b0);
      total++;
      if (po !== 8'h0F) begin bad++; $display("FAIL burst_f0_result: got %h want 0f", po); end
      idle_after_done("burst_f0");
      for (int i = 0; i < 6; i++) begin
         run_burst($urandom_range(1, 8), 1'($urandom), 1'b1);
         idle_after_done("burst_rand");
      end
   endtask

   task automatic test_burst_zero_sat();
      run_burst(0, 1'b0, 1'b1);
      idle_after_done("burst_zero");
      run_burst(15, 1'b1, 1'b1);
      idle_after_done("burst_sat_r");
      run_burst(9, 1'b0, 1'b1);
      idle_after_done("burst_sat_l");
   endtask

   task automatic test_reset_mid_burst();
      en = 1'b1; op = 3'b011; pi = 8'($urandom_range(1, 255)); burst_start = 1'b0;
      tick();
      burst_start = 1'b1; burst_len = 4'd6; burst_dir = 1'($urandom); en = 1'b0; si = 1'b1;
      tick();
      burst_start = 1'b0;
      tick();
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_po = 0; m_dir = 1'b1;
      total += 4;
      if (po !== 8'h00)  begin bad++; $display("FAIL midrst_po: got %h want 00", po); end
      if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
      if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", done); end
      if (so !== 1'b0)   begin bad++; $display("FAIL midrst_so: got %b want 0", so); end
      for (int i = 0; i < 6; i++) begin
         tick();
         total += 2;
         if (done !== 1'b0)   begin bad++; $display("FAIL midrst_no_done[%0d]: got %b want 0", i, done); end
         if (po !== 8'(m_po)) begin bad++; $display("FAIL midrst_po_hold[%0d]: got %h want %h", i, po, 8'(m_po)); end
      end
      $display("txn reset mid-burst: po=%h busy=%b done=%b", po, busy, done);
   endtask

   task automatic test_back_to_back();
      en = 1'b1; op = 3'b011; pi = 8'($urandom); burst_start = 1'b0;
      tick();
      model_op(3, 0, int'(pi));
      run_burst(3, 1'b1, 1'b1);
      run_burst(2, 1'b0, 1'b1);
      run_burst(0, 1'b1, 1'b1);
      run_burst(8, 1'b1, 1'b1);
      idle_after_done("b2b");
      $display("txn back-to-back: po=%h", po);
   endtask

   initial begin
      test_reset();
      test_directed_ops();
      test_random_ops();
      test_burst();
      test_burst_zero_sat();
      test_reset_mid_burst();
      test_back_to_back();
      test_random_ops();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
